// File: rtl/scoreboard_bcd.sv
// rtl/scoreboard_bcd.sv - multi-digit BCD up/down scoreboard with hold-to-erase and 7-seg outputs
module scoreboard_bcd #(
  parameter int DIGITS     = 2,
  parameter int ERASE_HOLD = 4,
  parameter int WRAP       = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                inc_i,
  input  logic                dec_i,
  input  logic                erase_i,
  output logic [4*DIGITS-1:0] bcd_o,
  output logic [7*DIGITS-1:0] seg_o,
  output logic                ovf_o,
  output logic                unf_o,
  output logic                erasing_o
);

  localparam int HW = $clog2(ERASE_HOLD + 1);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_WAIT_REL} state_t;

  state_t              r_state;
  logic [HW-1:0]       r_hold_cnt;
  logic                r_inc_q;
  logic                r_dec_q;
  logic [4*DIGITS-1:0] r_bcd;
  logic [7*DIGITS-1:0] r_seg;
  logic                r_ovf;
  logic                r_unf;
  logic                r_erasing;

  logic                w_inc_edge;
  logic                w_dec_edge;
  logic                w_carry;
  logic                w_borrow;
  logic [4*DIGITS-1:0] w_bcd_inc;
  logic [4*DIGITS-1:0] w_bcd_dec;

  assign w_inc_edge = inc_i & ~r_inc_q;
  assign w_dec_edge = dec_i & ~r_dec_q;

  // Ripple carry/borrow; a carry (borrow) out of the top digit means the count was at max (zero),
  // and the rippled result is then already the wrapped value.
  always_comb begin
    w_bcd_inc = r_bcd;
    w_bcd_dec = r_bcd;
    w_carry   = 1'b1;
    w_borrow  = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (w_carry) begin
        if (r_bcd[4*d +: 4] == 4'd9) begin
          w_bcd_inc[4*d +: 4] = 4'd0;
        end else begin
          w_bcd_inc[4*d +: 4] = r_bcd[4*d +: 4] + 4'd1;
          w_carry             = 1'b0;
        end
      end
      if (w_borrow) begin
        if (r_bcd[4*d +: 4] == 4'd0) begin
          w_bcd_dec[4*d +: 4] = 4'd9;
        end else begin
          w_bcd_dec[4*d +: 4] = r_bcd[4*d +: 4] - 4'd1;
          w_borrow            = 1'b0;
        end
      end
    end
  end

  function automatic logic [6:0] f_seg(input logic [3:0] digit);
    case (digit)
      4'd0:    f_seg = 7'h7E;
      4'd1:    f_seg = 7'h30;
      4'd2:    f_seg = 7'h6D;
      4'd3:    f_seg = 7'h79;
      4'd4:    f_seg = 7'h33;
      4'd5:    f_seg = 7'h5B;
      4'd6:    f_seg = 7'h5F;
      4'd7:    f_seg = 7'h70;
      4'd8:    f_seg = 7'h7F;
      4'd9:    f_seg = 7'h7B;
      default: f_seg = 7'h00;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_hold_cnt <= '0;
      r_inc_q    <= 1'b0;
      r_dec_q    <= 1'b0;
      r_bcd      <= '0;
      r_seg      <= {DIGITS{7'h7E}};
      r_ovf      <= 1'b0;
      r_unf      <= 1'b0;
      r_erasing  <= 1'b0;
    end else begin
      r_inc_q <= inc_i;
      r_dec_q <= dec_i;
      r_ovf   <= 1'b0;
      r_unf   <= 1'b0;
      for (int d = 0; d < DIGITS; d++) begin
        r_seg[7*d +: 7] <= f_seg(r_bcd[4*d +: 4]);
      end
      case (r_state)
        S_IDLE: begin
          if (w_inc_edge && !w_dec_edge) begin
            r_ovf <= w_carry;
            if (!w_carry || WRAP != 0) r_bcd <= w_bcd_inc;
          end else if (w_dec_edge && !w_inc_edge) begin
            r_unf <= w_borrow;
            if (!w_borrow || WRAP != 0) r_bcd <= w_bcd_dec;
          end
          if (erase_i) begin
            r_erasing  <= 1'b1;
            r_hold_cnt <= HW'(1);
            if (ERASE_HOLD == 1) begin
              r_bcd   <= '0;
              r_state <= S_WAIT_REL;
            end else begin
              r_state <= S_ARM;
            end
          end
        end
        S_ARM: begin
          if (!erase_i) begin
            r_state    <= S_IDLE;
            r_hold_cnt <= '0;
            r_erasing  <= 1'b0;
          end else if (r_hold_cnt + HW'(1) == HW'(ERASE_HOLD)) begin
            r_bcd      <= '0;
            r_hold_cnt <= HW'(ERASE_HOLD);
            r_state    <= S_WAIT_REL;
          end else begin
            r_hold_cnt <= r_hold_cnt + HW'(1);
          end
        end
        S_WAIT_REL: begin
          if (!erase_i) begin
            r_state    <= S_IDLE;
            r_hold_cnt <= '0;
            r_erasing  <= 1'b0;
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_hold_cnt <= '0;
          r_erasing  <= 1'b0;
        end
      endcase
    end
  end

  assign bcd_o     = r_bcd;
  assign seg_o     = r_seg;
  assign ovf_o     = r_ovf;
  assign unf_o     = r_unf;
  assign erasing_o = r_erasing;

endmodule

// File: tb/tb_scoreboard_bcd.sv
// tb/tb_scoreboard_bcd.sv - randomized and directed check of scoreboard_bcd against an integer score model
module tb_scoreboard_bcd;

  localparam int HOLD = 4;
  localparam int MAXV = 99;

  logic clk;
  logic rst_n;
  logic inc;
  logic dec;
  logic er;

  logic [7:0]  bcd0, bcd1;
  logic [13:0] seg0, seg1;
  logic        ovf0, ovf1, unf0, unf1, ers0, ers1;

  scoreboard_bcd #(.DIGITS(2), .ERASE_HOLD(HOLD), .WRAP(0)) u_sat (
    .clk(clk), .rst_n(rst_n), .inc_i(inc), .dec_i(dec), .erase_i(er),
    .bcd_o(bcd0), .seg_o(seg0), .ovf_o(ovf0), .unf_o(unf0), .erasing_o(ers0)
  );

  scoreboard_bcd #(.DIGITS(2), .ERASE_HOLD(HOLD), .WRAP(1)) u_wrap (
    .clk(clk), .rst_n(rst_n), .inc_i(inc), .dec_i(dec), .erase_i(er),
    .bcd_o(bcd1), .seg_o(seg1), .ovf_o(ovf1), .unf_o(unf1), .erasing_o(ers1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_checks;
  int n_fail;

  // Model: plain integer scores (index 0 saturating, 1 wrapping) and a run length of erase-high samples.
  int s[2];
  int ps[2];
  int run;
  bit m_iq, m_dq;
  bit m_ovf[2];
  bit m_unf[2];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] to_bcd(input int v);
    return 8'(((v / 10) << 4) | (v % 10));
  endfunction

  function automatic logic [6:0] seg_of(input int d);
    logic [6:0] tab [10];
    tab = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};
    return tab[d];
  endfunction

  function automatic logic [13:0] to_seg(input int v);
    return {seg_of(v / 10), seg_of(v % 10)};
  endfunction

  task automatic model_reset();
    s[0] = 0; s[1] = 0; ps[0] = 0; ps[1] = 0;
    run = 0; m_iq = 0; m_dq = 0;
    m_ovf[0] = 0; m_ovf[1] = 0; m_unf[0] = 0; m_unf[1] = 0;
  endtask

  task automatic model_edge(input bit i, input bit d, input bit e);
    bit idle, ie, de;
    idle = (run == 0);
    ie = i && !m_iq;
    de = d && !m_dq;
    for (int w = 0; w < 2; w++) begin
      ps[w] = s[w];
      m_ovf[w] = 0;
      m_unf[w] = 0;
      if (idle && ie && !de) begin
        if (s[w] == MAXV) begin m_ovf[w] = 1; if (w == 1) s[w] = 0; end
        else s[w] = s[w] + 1;
      end else if (idle && de && !ie) begin
        if (s[w] == 0) begin m_unf[w] = 1; if (w == 1) s[w] = MAXV; end
        else s[w] = s[w] - 1;
      end
    end
    run = e ? run + 1 : 0;
    if (run == HOLD) begin s[0] = 0; s[1] = 0; end
    m_iq = i;
    m_dq = d;
  endtask

  task automatic cyc(input bit i, input bit d, input bit e);
    inc = i; dec = d; er = e;
    @(posedge clk);
    model_edge(i, d, e);
    @(negedge clk);
    chk("bcd_sat",  32'(bcd0), 32'(to_bcd(s[0])));
    chk("bcd_wrap", 32'(bcd1), 32'(to_bcd(s[1])));
    chk("seg_sat",  32'(seg0), 32'(to_seg(ps[0])));
    chk("seg_wrap", 32'(seg1), 32'(to_seg(ps[1])));
    chk("ovf_sat",  32'(ovf0), 32'(m_ovf[0]));
    chk("ovf_wrap", 32'(ovf1), 32'(m_ovf[1]));
    chk("unf_sat",  32'(unf0), 32'(m_unf[0]));
    chk("unf_wrap", 32'(unf1), 32'(m_unf[1]));
    chk("ers_sat",  32'(ers0), 32'(run > 0));
    chk("ers_wrap", 32'(ers1), 32'(run > 0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0; inc = 0; dec = 0; er = 0;
    #1;
    chk("rst_bcd",  32'(bcd0), 32'h0);
    chk("rst_seg",  32'(seg0), 32'h3F7E);
    chk("rst_ers",  32'(ers0), 32'h0);
    chk("rst_ovf",  32'(ovf0 | unf0 | ovf1 | unf1), 32'h0);
    chk("rst_bcdw", 32'(bcd1), 32'h0);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulses(input bit up, input int n);
    for (int k = 0; k < n; k++) begin
      cyc(up, !up, 0);
      cyc(0, 0, 0);
    end
  endtask

  initial begin
    int er_left;
    n_checks = 0; n_fail = 0;
    rst_n = 1'b0; inc = 0; dec = 0; er = 0;
    model_reset();
    @(negedge clk);
    do_reset();

    pulses(1, 3);
    chk("three_inc", 32'(bcd0), 32'h03);
    cyc(0, 0, 0);
    chk("seg_03", 32'(seg0), 32'({7'h7E, 7'h79}));
    for (int k = 0; k < 10; k++) cyc(1, 0, 0);
    cyc(0, 0, 0);
    chk("held_inc", 32'(bcd0), 32'h04);

    pulses(1, 5);
    cyc(1, 0, 0);
    chk("carry", 32'(bcd0), 32'h10);
    cyc(0, 0, 0);
    cyc(0, 1, 0);
    chk("borrow", 32'(bcd0), 32'h09);
    cyc(0, 0, 0);
    cyc(1, 1, 0);
    chk("both_edges", 32'(bcd0), 32'h09);
    cyc(0, 0, 0);

    pulses(1, 90);
    cyc(1, 0, 0);
    chk("sat_ovf", 32'(ovf0), 32'h1);
    chk("sat_99", 32'(bcd0), 32'h99);
    chk("wrap_00", 32'(bcd1), 32'h00);
    cyc(0, 0, 0);

    do_reset();
    cyc(0, 1, 0);
    chk("sat_unf", 32'(unf0), 32'h1);
    chk("wrap_99", 32'(bcd1), 32'h99);
    cyc(0, 0, 0);

    do_reset();
    pulses(1, 42);
    for (int k = 0; k < 3; k++) cyc(0, 0, 1);
    cyc(0, 0, 0);
    chk("short_erase", 32'(bcd0), 32'h42);
    chk("short_ers", 32'(ers0), 32'h0);
    for (int k = 0; k < 8; k++) cyc(0, 0, 1);
    cyc(0, 0, 0);
    chk("long_erase", 32'(bcd0), 32'h00);
    chk("long_ers", 32'(ers0), 32'h0);

    for (int k = 0; k < 5; k++) cyc(0, 0, 1);
    cyc(1, 0, 1);
    cyc(1, 0, 1);
    cyc(1, 0, 0);
    cyc(1, 0, 0);
    cyc(0, 0, 0);
    chk("waitrel_inc", 32'(bcd0), 32'h00);

    do_reset();
    pulses(1, 55);
    cyc(0, 0, 1);
    cyc(0, 0, 1);
    do_reset();
    pulses(1, 1);
    for (int k = 0; k < 3; k++) cyc(0, 0, 1);
    cyc(0, 0, 0);
    chk("rearm_short", 32'(bcd0), 32'h01);
    for (int k = 0; k < 4; k++) cyc(0, 0, 1);
    cyc(0, 0, 0);
    chk("rearm_full", 32'(bcd0), 32'h00);

    er_left = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
        er_left = 0;
      end
      if (er_left == 0 && $urandom_range(0, 29) == 0) er_left = $urandom_range(1, 7);
      cyc(1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 3) == 0), er_left > 0);
      if (er_left > 0) er_left--;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
